inst_fetch_unit: RTL

Instruction fetch stage of the single-cycle RV32I core. It owns the program counter, issues word fetches to instruction memory over a request/response handshake, and buffers returned words in a small FIFO. It presents `instrCode` plus its PC to the decode/control stage with a valid/ready handshake. A redirect port from execute (branch/jump) flushes in-flight work and restarts fetch at a new address.

---
 rtl/inst_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to imem,
// and queues returned words with their PCs in a small FIFO for decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instrCode,
    output logic [31:0] instrPc,
    input  logic        instrReady
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic [31:0]    r_fifo_pc  [DEPTH];
    logic [31:0]    r_fifo_ins [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_redirect_pc;
    logic           w_unused_rpc_lsb;

    assign w_redirect_pc    = {redirectPc[31:2], 2'b00};
    assign w_unused_rpc_lsb = ^redirectPc[1:0];

    // Issuing reserves a FIFO slot, so a response in WAIT always has room.
    assign imemReq  = (r_state == S_IDLE) && (r_count < FULL) && !reset && !redirectValid;
    assign imemAddr = r_pc;
    assign w_accept = imemReq && imemReady;
    assign w_push   = (r_state == S_WAIT) && imemRvalid && !redirectValid;
    assign w_pop    = instrValid && instrReady && !redirectValid;

    assign instrValid = (r_count != '0);
    assign instrCode  = r_fifo_ins[r_rd_ptr];
    assign instrPc    = r_fifo_pc[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        if (redirectValid) begin
            // A response landing with the redirect retires the outstanding fetch
            // (in WAIT or DROP); otherwise a WAIT fetch must be dropped later.
            if (r_state != S_IDLE && imemRvalid) begin
                w_state_nxt = S_IDLE;
            end else if (r_state == S_WAIT) begin
                w_state_nxt = S_DROP;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_accept)   w_state_nxt = S_WAIT;
                S_WAIT: if (imemRvalid) w_state_nxt = S_IDLE;
                S_DROP: if (imemRvalid) w_state_nxt = S_IDLE;
                default:                w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirectValid) begin
            r_pc <= w_redirect_pc;
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_pc <= RESET_PC;
        end else if (w_accept) begin
            r_req_pc <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirectValid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= r_req_pc;
            r_fifo_ins[r_wr_ptr] <= imemRdata;
        end
    end

endmodule
